// File: rtl/int_xbar_pkg.sv
// Shared constants, line-mode type and mode lookup for the interrupt crossbar.
// Used by int_xbar_sync and int_sync_cell.
package int_xbar_pkg;

  localparam int MAX_NUM_IN      = 64;
  localparam int MAX_SYNC_STAGES = 4;

  typedef enum logic {
    INT_LEVEL = 1'b0,
    INT_EDGE  = 1'b1
  } int_mode_e;

  function automatic int_mode_e line_mode(input logic [MAX_NUM_IN-1:0] mask, input int idx);
    return mask[idx] ? INT_EDGE : INT_LEVEL;
  endfunction

endpackage

// File: rtl/int_sync_cell.sv
// One interrupt line: synchronizer chain followed by level pass-through or
// rising-edge detect with a sticky pending flop, selected by MODE.
module int_sync_cell
  import int_xbar_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter int_mode_e MODE        = INT_LEVEL
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  input  logic clr,
  input  logic en,
  output logic pend_next,
  output logic int_next
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (MODE == INT_EDGE) begin : g_edge
    logic prev_q;
    logic pend_q;
    logic rise;

    // A rise in the same cycle as a clear keeps the line pending.
    assign rise      = s & ~prev_q;
    assign pend_next = rise | (pend_q & ~clr);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        prev_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        prev_q <= s;
        pend_q <= pend_next;
      end
    end
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr;
    assign pend_next  = s;
  end

  assign int_next = pend_next & en;

endmodule

// File: rtl/int_xbar_sync.sv
// Synchronizing interrupt crossbar: per-line sync/edge cells, enable register,
// registered outputs. Define INT_XBAR_EDGE_EN to honour EDGE_MASK and clearing.
module int_xbar_sync
  import int_xbar_pkg::*;
#(
  parameter int                NUM_IN      = 5,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_IN-1:0] EDGE_MASK   = '0,
  parameter logic [NUM_IN-1:0] EN_RESET    = '1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_IN-1:0] auto_int_in,
  input  logic              cfg_en_wr,
  input  logic [NUM_IN-1:0] cfg_en_data,
  input  logic              clr_valid,
  input  logic [NUM_IN-1:0] clr_mask,
  output logic [NUM_IN-1:0] auto_int_out,
  output logic              auto_int_any,
  output logic [NUM_IN-1:0] pending_o
);

  if (NUM_IN < 1 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("int_xbar_sync: NUM_IN out of range");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("int_xbar_sync: SYNC_STAGES out of range");
  end

  localparam logic [MAX_NUM_IN-1:0] EDGE_MASK_EXT = MAX_NUM_IN'(EDGE_MASK);

  logic [NUM_IN-1:0] en_q;
  logic [NUM_IN-1:0] en_next;
  logic [NUM_IN-1:0] clr_line;
  logic [NUM_IN-1:0] pend_next;
  logic [NUM_IN-1:0] int_next;

  // The mask write takes effect on the output in the same edge that loads it.
  assign en_next = cfg_en_wr ? cfg_en_data : en_q;

`ifdef INT_XBAR_EDGE_EN
  assign clr_line = clr_valid ? clr_mask : '0;
`else
  logic unused_clr;
  assign unused_clr = clr_valid ^ (^clr_mask);
  assign clr_line   = '0;
`endif

  for (genvar i = 0; i < NUM_IN; i++) begin : g_line
    int_sync_cell #(
      .SYNC_STAGES (SYNC_STAGES),
`ifdef INT_XBAR_EDGE_EN
      .MODE        (line_mode(EDGE_MASK_EXT, i))
`else
      .MODE        (INT_LEVEL)
`endif
    ) u_cell (
      .clock     (clock),
      .reset_n   (reset_n),
      .async_in  (auto_int_in[i]),
      .clr       (clr_line[i]),
      .en        (en_next[i]),
      .pend_next (pend_next[i]),
      .int_next  (int_next[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q         <= EN_RESET;
      auto_int_out <= '0;
      pending_o    <= '0;
    end else begin
      en_q         <= en_next;
      auto_int_out <= int_next;
      pending_o    <= pend_next;
    end
  end

  assign auto_int_any = |auto_int_out;

endmodule

// File: tb/tb_int_xbar_sync.sv
// Self-checking bench for int_xbar_sync: directed sequences, a settled-state
// vector table and randomized traffic against a delay-line reference model.
module tb_int_xbar_sync;

  localparam int NUM_IN = 5;
  localparam int SS     = 2;
`ifdef INT_XBAR_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif
  localparam logic [4:0] EDGE_LINES = EDGE_ON ? 5'b00110 : 5'b00000;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] auto_int_in;
  logic       cfg_en_wr;
  logic [4:0] cfg_en_data;
  logic       clr_valid;
  logic [4:0] clr_mask;
  logic [4:0] auto_int_out;
  logic       auto_int_any;
  logic [4:0] pending_o;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  int_xbar_sync #(
    .NUM_IN      (NUM_IN),
    .SYNC_STAGES (SS),
    .EDGE_MASK   (5'b00110),
    .EN_RESET    (5'b11111)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .auto_int_in  (auto_int_in),
    .cfg_en_wr    (cfg_en_wr),
    .cfg_en_data  (cfg_en_data),
    .clr_valid    (clr_valid),
    .clr_mask     (clr_mask),
    .auto_int_out (auto_int_out),
    .auto_int_any (auto_int_any),
    .pending_o    (pending_o)
  );

  // Reference model: inputs go through an SS-deep delay queue, then the
  // level/edge/pending rules are applied with whole-vector arithmetic.
  logic [4:0] dl[$];
  logic [4:0] m_prev, m_pend, m_en, m_out;
  logic [4:0] m_s, m_rise, m_clr, m_en_n;

  task automatic model_reset();
    dl = {};
    for (int i = 0; i < SS; i++) dl.push_back(5'b0);
    m_prev = '0;
    m_pend = '0;
    m_en   = 5'b11111;
    m_out  = '0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      m_s = dl.pop_front();
      dl.push_back(auto_int_in);
      m_rise = m_s & ~m_prev & EDGE_LINES;
      m_prev = m_s;
      m_clr  = clr_valid ? clr_mask : 5'b0;
      m_pend = (m_s & ~EDGE_LINES) | m_rise | (m_pend & EDGE_LINES & ~m_clr);
      m_en_n = cfg_en_wr ? cfg_en_data : m_en;
      m_en   = m_en_n;
      m_out  = m_pend & m_en_n;
    end
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [4:0] in;
    logic [4:0] en;
    logic [4:0] clr;
    logic [4:0] out_e;
    logic [4:0] pend_e;
    logic [4:0] out_l;
    logic [4:0] pend_l;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[1] = '{5'b00111, 5'b11111, 5'b00000, 5'b00111, 5'b00111, 5'b00111, 5'b00111};
    tbl[2] = '{5'b00000, 5'b11111, 5'b00000, 5'b00110, 5'b00110, 5'b00000, 5'b00000};
    tbl[3] = '{5'b11000, 5'b01111, 5'b00000, 5'b01110, 5'b11110, 5'b01000, 5'b11000};
    tbl[4] = '{5'b11000, 5'b11111, 5'b11111, 5'b11000, 5'b11000, 5'b11000, 5'b11000};
    tbl[5] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00010};
    tbl[6] = '{5'b00000, 5'b11111, 5'b00000, 5'b00010, 5'b00010, 5'b00000, 5'b00000};

    reset_n     = 1'b0;
    auto_int_in = '0;
    cfg_en_wr   = 1'b0;
    cfg_en_data = '0;
    clr_valid   = 1'b0;
    clr_mask    = '0;
    steps(2);
    reset_n = 1'b1;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out", auto_int_out, 5'b0);
      check("rst_any", auto_int_any, 5'b0);
      check("rst_pend", pending_o, 5'b0);
    end
    check("rst_en", dut.en_q, 5'b11111);

    // Level latency on line 0
    auto_int_in = 5'b00001;
    step(); check("lvl_k0", auto_int_out[0], 5'd0);
    step(); check("lvl_k1", auto_int_out[0], 5'd0);
    step(); check("lvl_k2", auto_int_out[0], 5'd1);
    check("lvl_any_hi", auto_int_any, 5'd1);
    auto_int_in = 5'b00000;
    step(); check("lvl_fall1", auto_int_out[0], 5'd1);
    step(); check("lvl_fall2", auto_int_out[0], 5'd1);
    step(); check("lvl_fall3", auto_int_out[0], 5'd0);
    check("lvl_any_lo", auto_int_any, 5'd0);

    // Edge capture and clear on line 1
    auto_int_in = 5'b00010;
    steps(2);
    auto_int_in = 5'b00000;
    step(); check("edge_set", auto_int_out[1], 5'd1);
    steps(2); check("edge_hold", auto_int_out[1], EDGE_ON ? 5'd1 : 5'd0);
    clr_valid = 1'b1; clr_mask = 5'b00010;
    step();
    clr_valid = 1'b0; clr_mask = 5'b0;
    check("edge_clr_out", auto_int_out[1], 5'd0);
    check("edge_clr_pend", pending_o[1], 5'd0);

    // Clear coinciding with rise on line 2
    auto_int_in = 5'b00100;
    steps(2);
    check("coll_pre", pending_o[2], 5'd0);
    clr_valid = 1'b1; clr_mask = 5'b00100;
    step();
    clr_valid = 1'b0; clr_mask = 5'b0;
    check("coll_set_wins", pending_o[2], 5'd1);
    auto_int_in = 5'b00000;
    steps(4);
    check("coll_after", pending_o[2], EDGE_ON ? 5'd1 : 5'd0);

    // Masking a pending line, then re-enabling it
    cfg_en_wr = 1'b1; cfg_en_data = 5'b11101;
    step();
    cfg_en_wr = 1'b0;
    check("mask_out", auto_int_out[2], 5'd0);
    check("mask_pend", pending_o[2], EDGE_ON ? 5'd1 : 5'd0);
    cfg_en_wr = 1'b1; cfg_en_data = 5'b11111;
    step();
    cfg_en_wr = 1'b0;
    check("unmask_out", auto_int_out[2], EDGE_ON ? 5'd1 : 5'd0);

    // Asynchronous reset mid-operation with lines 1,2 active
    auto_int_in = 5'b00110;
    steps(4);
    check("preirq_out", auto_int_out, 5'b00110);
    #2 reset_n = 1'b0;
    #1;
    check("async_out", auto_int_out, 5'b0);
    check("async_any", auto_int_any, 5'b0);
    check("async_pend", pending_o, 5'b0);
    check("async_en", dut.en_q, 5'b11111);
    step();
    reset_n = 1'b1;
    steps(2); check("held_fill", auto_int_out, 5'b0);
    step();   check("held_rise", auto_int_out, 5'b00110);
    auto_int_in = 5'b00000;
    steps(4);
    check("held_sticky", auto_int_out, EDGE_ON ? 5'b00110 : 5'b00000);

    // Settled-state vector table
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int r = 0; r < 7; r++) begin
      auto_int_in = tbl[r].in;
      cfg_en_wr   = 1'b1;
      cfg_en_data = tbl[r].en;
      clr_valid   = (tbl[r].clr != 5'b0);
      clr_mask    = tbl[r].clr;
      step();
      cfg_en_wr = 1'b0;
      clr_valid = 1'b0;
      clr_mask  = '0;
      steps(3);
      check($sformatf("tbl%0d_out", r), auto_int_out, EDGE_ON ? tbl[r].out_e : tbl[r].out_l);
      check($sformatf("tbl%0d_pend", r), pending_o, EDGE_ON ? tbl[r].pend_e : tbl[r].pend_l);
      check($sformatf("tbl%0d_any", r), auto_int_any,
            5'(|(EDGE_ON ? tbl[r].out_e : tbl[r].out_l)));
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      auto_int_in = 5'($urandom_range(0, 31));
      cfg_en_wr   = ($urandom_range(0, 7) == 0);
      cfg_en_data = 5'($urandom_range(0, 31));
      clr_valid   = ($urandom_range(0, 3) == 0);
      clr_mask    = 5'($urandom_range(0, 31));
      step();
      check("rnd_out", auto_int_out, m_out);
      check("rnd_any", auto_int_any, 5'(|m_out));
      check("rnd_pend", pending_o, m_pend);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
